// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the multi-cycle shifter (seq_shifter / shift_step).
package shift_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-step shifter: moves value by n (0..STEP) positions.
// Rotate-right exists only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise op=10 acts as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int NW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [NW-1:0]    n,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] w_ones;

  always_comb begin
    w_ones = '1;
    case (op)
      OP_SRL:  result = value >> n;
      // Fill vacated top bits from the sign captured at accept time.
      OP_SRA:  result = (value >> n) | (sign ? ~(w_ones >> n) : '0);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROTR: result = (value >> n) | (value << (WIDTH - int'(n)));
`endif
      default: result = value << n;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA unit with start/done handshake, at most STEP bits per clock.
// Define SEQ_SHIFTER_ROTATE_EN to enable rotate-right on op=10.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHAMT_W = calc_shamt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   y
);

  localparam int NW = $clog2(STEP + 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_val;
  logic [SHAMT_W-1:0] r_rem;
  logic [1:0]         r_op;
  logic               r_sign;
  logic [WIDTH-1:0]   r_y;
  logic               r_ready;
  logic               r_done;

  logic [NW-1:0]      w_n;
  logic [SHAMT_W-1:0] w_rem_next;
  logic [WIDTH-1:0]   w_step;

  always_comb begin
    if (int'(r_rem) >= STEP) w_n = NW'(STEP);
    else                     w_n = NW'(r_rem);
    w_rem_next = r_rem - SHAMT_W'(w_n);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value  (r_val),
    .n      (w_n),
    .op     (r_op),
    .sign   (r_sign),
    .result (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = (shamt == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_rem_next == '0) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ready/done are registered from the next state so neither has a path from start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= '0;
      r_rem   <= '0;
      r_op    <= OP_SLL;
      r_sign  <= 1'b0;
      r_y     <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next == ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_val  <= a;
            r_op   <= op;
            r_rem  <= shamt;
            r_sign <= a[WIDTH-1];
            if (shamt == '0) r_y <= a;
          end
        end
        ST_RUN: begin
          r_val <= w_step;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) r_y <= w_step;
        end
        default: ;
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign y     = r_y;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed scoreboard bench for seq_shifter (WIDTH=32, STEP=4).
module tb_seq_shifter;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        ready;
  logic        done;
  logic [31:0] y;

  typedef struct {
    logic [31:0] y;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .shamt (shamt),
    .ready (ready),
    .done  (done),
    .y     (y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'b0, ready}, 32'd1);
  endtask

  // mode 0: plain; 1: scramble inputs during RUN; 2: pulse start during RUN and DONE
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [4:0] sh, input logic [31:0] ey, input int mode);
    exp_t e;
    int   edges;
    wait_ready();
    @(negedge clk);
    start = 1'b1; op = o; a = av; shamt = sh;
    e.y   = ey;
    e.lat = 1 + (int'(sh) + 3) / 4;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    if (mode == 1) begin a = 32'h0; op = OP_SRA; shamt = 5'd0; end
    while (done !== 1'b1 && edges < 60) begin
      check({tag, "_ready_run"}, {31'b0, ready}, 32'd0);
      if (mode == 2) begin start = 1'b1; a = $urandom; shamt = 5'($urandom); end
      @(posedge clk); #1;
      edges++;
    end
    e = sb.pop_front();
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_latency"}, edges, e.lat);
    check({tag, "_y"}, y, e.y);
    check({tag, "_ready_done"}, {31'b0, ready}, 32'd0);
    if (mode == 2) start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, ready}, 32'd1);
    check({tag, "_y_hold"}, y, e.y);
    start = 1'b0;
    if (mode == 2) begin
      @(posedge clk); #1;
      check({tag, "_no_accept"}, {31'b0, ready}, 32'd1);
    end
  endtask

  initial begin
    logic        saw_done;
    logic [31:0] rot_exp;
    rst_n = 1'b0; start = 1'b0; op = OP_SLL; a = '0; shamt = '0;
    #13;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_y", y, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("sra31", OP_SRA, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 0);
    run_op("sll0",  OP_SLL, 32'h0000_0001, 5'd0,  32'h0000_0001, 0);
    run_op("srl5",  OP_SRL, 32'hF000_0000, 5'd5,  32'h0780_0000, 1);
    run_op("sll4",  OP_SLL, 32'h1234_5678, 5'd4,  32'h2345_6780, 2);
    run_op("sra7p", OP_SRA, 32'h7000_0000, 5'd7,  32'h00E0_0000, 0);
    run_op("sra1n", OP_SRA, 32'h8000_0000, 5'd1,  32'hC000_0000, 0);
    run_op("srl8",  OP_SRL, 32'hDEAD_BEEF, 5'd8,  32'h00DE_ADBE, 2);
    run_op("sll31", OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 0);

    wait_ready();
    @(negedge clk);
    start = 1'b1; op = OP_SLL; a = 32'h0000_0001; shamt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", y, 32'h0);
    check("async_rst_ready", {31'b0, ready}, 32'd1);
    check("async_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("no_done_after_rst", {31'b0, saw_done}, 32'd0);
    run_op("sll20", OP_SLL, 32'h0000_0001, 5'd20, 32'h0010_0000, 0);

`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_exp = 32'h1000_000F;
`else
    rot_exp = 32'h0000_0F10;
`endif
    run_op("op10", OP_ROTR, 32'h0000_00F1, 5'd4, rot_exp, 0);

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shift unit for the multicycle MIPS datapath, the successor to the fixed left-shift-by-2 branch-offset shifter. It performs SLL/SRL/SRA on a WIDTH-bit operand by a variable amount, advancing at most STEP bit positions per clock so the critical path stays short. It sits beside the ALU and is driven by the control FSM through a start/done handshake.

## Interface
- WIDTH, 32: operand and result width. Must be a power of two, 8 or greater.
- STEP, 4: maximum bit positions shifted per cycle. Must be a power of two in 1..WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- op  in  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 ROTR (see Configuration).
- a  in  WIDTH  operand.
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- ready  out  1  high only in IDLE.
- done  out  1  single-cycle pulse; y is valid in that cycle.
- y  out  WIDTH  result register; holds its value until the next accepted start.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: ready=1. When start=1, the rising edge captures a, op and shamt into internal registers, sets remaining=shamt and captures sign=a[WIDTH-1].
  - If shamt=0, the next state is DONE.
  - Otherwise the next state is RUN.
- RUN: each edge shifts the working value by n=min(STEP, remaining) and sets remaining -= n.
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the captured sign.
  - When the new remaining is 0, the next state is DONE.
- DONE: done=1 and y=result for exactly one cycle. The next state is IDLE.
- The input ports a, op and shamt are ignored after the capture edge. Changing them mid-operation has no effect.
- start is ignored outside IDLE. There is no queueing.
- start is not sampled in DONE, so back-to-back operations are spaced by one IDLE cycle.
- All arithmetic is unsigned on SHAMT_W bits. remaining never underflows.

## Timing
- Reset values: state=IDLE, ready=1, done=0, y=0, remaining=0.
- Latency: the done cycle begins 1+ceil(shamt/STEP) rising edges after and including the accepting edge.
  - Example with STEP=4: shamt=0 gives 1 edge, shamt=4 gives 2 edges, shamt=31 gives 9 edges.
- Throughput: one operation per (latency+1) cycles.
- ready and done are never high together.
- y updates only on the edge entering DONE.
- If rst_n is asserted mid-operation, the block returns to IDLE immediately, clears y, and drops done. The interrupted operation produces no done pulse.
- done and ready are registered outputs, with no combinational path from start.

## Configuration
- SEQ_SHIFTER_ROTATE_EN
  - Defined: op=10 performs rotate-right by shamt. Bits shifted out of bit 0 re-enter at bit WIDTH-1 at the same STEP-per-cycle rate and with the same latency.
  - Not defined: op=10 is decoded as SLL and the rotate datapath is absent.

## Structure
- Package shift_pkg holds:
  - op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROTR;
  - the FSM state enum;
  - a localparam function computing SHAMT_W.
- Sub-module shift_step is a combinational single-step shifter. It takes value, n (0..STEP), op and sign, and returns the shifted value. It is instantiated once, and seq_shifter holds the FSM and registers.

## Test plan
- Reset, then start with a=0x8000_0001, op=SRA, shamt=31, STEP=4 -> done on the 9th edge, y=0xFFFF_FFFF. ready stays low throughout RUN and DONE.
- Start with a=0x0000_0001, op=SLL, shamt=0 -> done one edge after accept, y=0x0000_0001.
- Start with a=0xF000_0000, op=SRL, shamt=5 -> y=0x0780_0000 after 3 edges. a is changed to 0 during RUN, and y is unaffected.
- Start pulsed during RUN and during DONE -> the pulse is ignored. Exactly one done is produced, and the next start is accepted only once ready=1.
- rst_n asserted mid-RUN of an SLL by 20 -> y=0, ready=1, done=0 asynchronously. No done pulse follows, and a fresh start completes normally.
- With SEQ_SHIFTER_ROTATE_EN: a=0x0000_00F1, op=ROTR, shamt=4 -> y=0x1000_000F after 2 edges.
- Without SEQ_SHIFTER_ROTATE_EN: the same stimulus gives y=0x0000_0F10.
